mul_sequencer: RTL

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 42 ++++
 rtl/mul_sequencer_if.sv | 39 +++
 rtl/mul_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared constants for the iterative multiply sequencer.
//   - operand / status / ALU command widths
//   - ALU command encodings used by the sequencer (ADD, MOV)
//   - 2-bit FSM state encoding
//   - status flag bit positions within {Z,C,N,V}
//   - mul_flags(): builds the flag word written on completion
package mul_sequencer_pkg;

  localparam int REGISTER_FILE_LEN = 32;
  localparam int STATUS_REG_LEN    = 4;
  localparam int EXEC_COMMAND_LEN  = 4;

  localparam logic [EXEC_COMMAND_LEN-1:0] EXEC_MOV = 4'h0;
  localparam logic [EXEC_COMMAND_LEN-1:0] EXEC_ADD = 4'h1;

  // Status word is {Z,C,N,V}, Z in the MSB.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

  // Z and N come from the product; C and V are passed through from the
  // status captured at start (the ALU carry/overflow are meaningless here).
  function automatic logic [STATUS_REG_LEN-1:0] mul_flags(
    input logic                      zero,
    input logic                      neg,
    input logic [STATUS_REG_LEN-1:0] latched
  );
    logic [STATUS_REG_LEN-1:0] f;
    f         = latched;
    f[FLAG_Z] = zero;
    f[FLAG_N] = neg;
    return f;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/response handshake plus the shared-ALU drive and
// return signals of the multiply sequencer.
//   master: requester side (drives start/operands, models or owns the ALU)
//   slave : the sequencer (drives busy/done/result/status, ALU operands)
interface mul_sequencer_if #(
  parameter int WIDTH = mul_sequencer_pkg::REGISTER_FILE_LEN
);
  // request
  logic                                         start;
  logic [WIDTH-1:0]                             op_a;
  logic [WIDTH-1:0]                             op_b;
  logic                                         set_flags;
  logic [mul_sequencer_pkg::STATUS_REG_LEN-1:0] status_in;
  // response
  logic                                         busy;
  logic                                         done;
  logic [WIDTH-1:0]                             result;
  logic [mul_sequencer_pkg::STATUS_REG_LEN-1:0] status_out;
  logic                                         status_wr;
  // shared ALU
  logic [WIDTH-1:0]                             alu_val_1;
  logic [WIDTH-1:0]                             alu_val_2;
  logic [mul_sequencer_pkg::EXEC_COMMAND_LEN-1:0] alu_exec_cmd;
  logic                                         alu_carry_in;
  logic [WIDTH-1:0]                             alu_res;
  logic [mul_sequencer_pkg::STATUS_REG_LEN-1:0] alu_status;

  modport master (
    output start, op_a, op_b, set_flags, status_in, alu_res, alu_status,
    input  busy, done, result, status_out, status_wr,
           alu_val_1, alu_val_2, alu_exec_cmd, alu_carry_in
  );

  modport slave (
    input  start, op_a, op_b, set_flags, status_in, alu_res, alu_status,
    output busy, done, result, status_out, status_wr,
           alu_val_1, alu_val_2, alu_exec_cmd, alu_carry_in
  );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-and-add multiplier that borrows the shared ALU for its
// additions. One multiplier bit is consumed per CALC cycle, stopping as soon
// as the remaining multiplier bits are all zero.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mul_sequencer_if.slave: start/op_a/op_b/set_flags/status_in in,
//          busy/done/result/status_out/status_wr out, alu_* drive and return
// Product is modulo 2^WIDTH, so signed and unsigned operands give the same bits.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = REGISTER_FILE_LEN
) (
  input  logic            clk,
  input  logic            rst,
  mul_sequencer_if.slave  bus
);

  mul_state_t                state_q, state_d;
  logic [WIDTH-1:0]          acc_q, acc_d;
  logic [WIDTH-1:0]          mcand_q, mcand_d;
  logic [WIDTH-1:0]          mplier_q, mplier_d;
  logic                      sflag_q, sflag_d;
  logic [STATUS_REG_LEN-1:0] stat_q, stat_d;

  logic                      accept;
  logic [WIDTH-1:0]          mplier_nxt;
  logic [STATUS_REG_LEN-1:0] alu_status_unused;

  assign alu_status_unused = bus.alu_status;

  // start is only looked at when not iterating; DONE may accept directly.
  assign accept     = (state_q != ST_CALC) && bus.start;
  assign mplier_nxt = mplier_q >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sflag_q  <= 1'b0;
      stat_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sflag_q  <= sflag_d;
      stat_q   <= stat_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    mcand_d          = mcand_q;
    mplier_d         = mplier_q;
    sflag_d          = sflag_q;
    stat_d           = stat_q;
    bus.alu_val_1    = '0;
    bus.alu_val_2    = '0;
    bus.alu_exec_cmd = EXEC_MOV;
    bus.alu_carry_in = 1'b0;

    case (state_q)
      ST_CALC: begin
        bus.alu_val_1    = acc_q;
        bus.alu_val_2    = mcand_q;
        bus.alu_exec_cmd = EXEC_ADD;
        if (mplier_q[0]) acc_d = bus.alu_res;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nxt;
        // early exit once no set multiplier bits remain
        if (mplier_nxt == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      acc_d    = '0;
      mcand_d  = bus.op_a;
      mplier_d = bus.op_b;
      sflag_d  = bus.set_flags;
      stat_d   = bus.status_in;
      state_d  = (bus.op_b != '0) ? ST_CALC : ST_DONE;
    end
  end

  assign bus.busy      = (state_q == ST_CALC);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = acc_q;
  assign bus.status_wr = bus.done && sflag_q;
  assign bus.status_out = sflag_q ? mul_flags(acc_q == '0, acc_q[WIDTH-1], stat_q)
                                  : stat_q;

endmodule
